pp_ram_rd_ctrl: RTL and testbench

Parametrised multi-bank read controller for the DL sample RAM. It serves NUM_BANKS equal banks in one address space, each bank written by the write controller. When the write side flags a bank full, this block streams that bank's addresses to the RAM read port, honouring downstream backpressure. It then signals completion back to the write controller. Generalises the fixed 2-bank/38-word reader with a bank count parameter, round-robin arbitration, a stall input, RAM-latency-aligned data valid, and re-arm protection.

---
 rtl/pp_ram_pkg.sv | 19 +
 rtl/pp_ram_rd_ctrl_arb.sv | 33 +++
 rtl/pp_ram_rd_ctrl.sv | 163 ++++++++++++++++
 tb/tb_pp_ram_rd_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pp_ram_pkg.sv
// Shared types and default DL bank geometry for the ping-pong sample RAM read controller.
package pp_ram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } rd_state_e;

    localparam int DL_BANK_DEPTH  = 38;
    localparam int DL_BANK_STRIDE = 64;

    // Bank index width, never narrower than one bit.
    function automatic int bank_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pp_ram_rd_ctrl_arb.sv
// Combinational round-robin picker: first eligible bank at or after the pointer, with wrap.
module pp_rr_arb
    import pp_ram_pkg::*;
#(
    parameter int NUM_BANKS = 2,
    parameter int BANK_W    = bank_idx_w(NUM_BANKS)
) (
    input  logic [NUM_BANKS-1:0] i_elig,
    input  logic [BANK_W-1:0]    i_ptr,
    output logic [BANK_W-1:0]    o_grant,
    output logic                 o_gnt_vld
);

    int w_dist;
    int w_best;

    // Distance from the pointer decides priority; the smallest wins.
    always_comb begin
        o_grant   = '0;
        o_gnt_vld = 1'b0;
        w_best    = NUM_BANKS;
        w_dist    = 0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_dist = (b + NUM_BANKS - int'(i_ptr)) % NUM_BANKS;
            if (i_elig[b] && (w_dist < w_best)) begin
                w_best    = w_dist;
                o_grant   = BANK_W'(b);
                o_gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pp_ram_rd_ctrl.sv
// Multi-bank DL sample RAM read controller with round-robin bank selection and latency-aligned valid.
// Optional macro PP_RDCTL_DONE_HANDSHAKE_EN: hold rd_done until the bank's wr_full drops.
module pp_ram_rd_ctrl
    import pp_ram_pkg::*;
#(
    parameter int NUM_BANKS   = 2,
    parameter int BANK_DEPTH  = DL_BANK_DEPTH,
    parameter int BANK_STRIDE = DL_BANK_STRIDE,
    parameter int ADDR_W      = 7,
    parameter int RD_LAT      = 1,
    parameter int HOLD_CYCLES = 20
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_BANKS-1:0]               wr_full,
    output logic [NUM_BANKS-1:0]               rd_done,
    input  logic                               rd_ready,
    output logic                               rd_en,
    output logic [ADDR_W-1:0]                  rd_addr,
    output logic [bank_idx_w(NUM_BANKS)-1:0]   rd_bank,
    output logic                               rd_valid,
    output logic                               rd_last,
    output logic                               busy
);

    localparam int BANK_W = bank_idx_w(NUM_BANKS);
    localparam int CNT_W  = (BANK_DEPTH <= 2) ? 1 : $clog2(BANK_DEPTH);
    localparam int TMR_W  = $clog2(HOLD_CYCLES + RD_LAT + 1);

    if ((NUM_BANKS < 2) || (NUM_BANKS > 8) || (BANK_DEPTH < 1) || (BANK_STRIDE < BANK_DEPTH) ||
        (RD_LAT < 1) || (RD_LAT > 4) || (HOLD_CYCLES < 1) ||
        ((NUM_BANKS - 1) * BANK_STRIDE + BANK_DEPTH - 1 >= (1 << ADDR_W))) begin : g_bad_params
        $error("pp_ram_rd_ctrl: illegal parameter combination");
    end

    rd_state_e              r_state;
    logic [BANK_W-1:0]      r_bank;
    logic [BANK_W-1:0]      r_ptr;
    logic [ADDR_W-1:0]      r_base;
    logic [CNT_W-1:0]       r_cnt;
    logic [TMR_W-1:0]       r_tmr;
    logic [NUM_BANKS-1:0]   r_armed;
    logic [NUM_BANKS-1:0]   r_rd_done;
    logic                   r_rd_en;
    logic [ADDR_W-1:0]      r_rd_addr;
    logic                   r_last_iss;
    logic [RD_LAT-1:0]      r_vld_p;
    logic [RD_LAT-1:0]      r_last_p;

    logic [NUM_BANKS-1:0]   w_elig;
    logic [BANK_W-1:0]      w_grant;
    logic                   w_gnt_vld;
    logic [ADDR_W-1:0]      w_base;
    logic [BANK_W-1:0]      w_next_ptr;

    assign w_elig     = wr_full & r_armed;
    assign w_base     = ADDR_W'(32'(w_grant) * 32'(BANK_STRIDE));
    assign w_next_ptr = (r_bank == BANK_W'(NUM_BANKS - 1)) ? '0 : r_bank + 1'b1;

    pp_rr_arb #(
        .NUM_BANKS (NUM_BANKS),
        .BANK_W    (BANK_W)
    ) u_arb (
        .i_elig    (w_elig),
        .i_ptr     (r_ptr),
        .o_grant   (w_grant),
        .o_gnt_vld (w_gnt_vld)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_bank     <= '0;
            r_ptr      <= '0;
            r_base     <= '0;
            r_cnt      <= '0;
            r_tmr      <= '0;
            r_armed    <= '1;
            r_rd_done  <= '0;
            r_rd_en    <= 1'b0;
            r_rd_addr  <= '0;
            r_last_iss <= 1'b0;
            r_vld_p    <= '0;
            r_last_p   <= '0;
        end else begin
            // Latency pipe shifts regardless of state so in-flight reads always emerge.
            r_vld_p[0]  <= r_rd_en;
            r_last_p[0] <= r_last_iss;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld_p[i]  <= r_vld_p[i-1];
                r_last_p[i] <= r_last_p[i-1];
            end

            r_armed    <= r_armed | ~wr_full;
            r_rd_en    <= 1'b0;
            r_last_iss <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_vld) begin
                        r_bank  <= w_grant;
                        r_base  <= w_base;
                        r_cnt   <= '0;
                        r_state <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (rd_ready) begin
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= r_base + ADDR_W'(r_cnt);
                        if (r_cnt == CNT_W'(BANK_DEPTH - 1)) begin
                            r_last_iss <= 1'b1;
                            r_tmr      <= '0;
                            r_state    <= ST_DRAIN;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (r_tmr == TMR_W'(RD_LAT - 1)) begin
                        r_tmr            <= '0;
                        r_rd_done        <= NUM_BANKS'(1) << r_bank;
                        r_armed[r_bank]  <= 1'b0;
                        r_ptr            <= w_next_ptr;
                        r_state          <= ST_DONE;
                    end else begin
                        r_tmr <= r_tmr + 1'b1;
                    end
                end
                ST_DONE: begin
`ifdef PP_RDCTL_DONE_HANDSHAKE_EN
                    if ((r_tmr >= TMR_W'(HOLD_CYCLES - 1)) && !wr_full[r_bank]) begin
                        r_rd_done <= '0;
                        r_tmr     <= '0;
                        r_state   <= ST_IDLE;
                    end else if (r_tmr < TMR_W'(HOLD_CYCLES - 1)) begin
                        r_tmr <= r_tmr + 1'b1;
                    end
`else
                    if (r_tmr == TMR_W'(HOLD_CYCLES - 1)) begin
                        r_rd_done <= '0;
                        r_tmr     <= '0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_tmr <= r_tmr + 1'b1;
                    end
`endif
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rd_done  = r_rd_done;
    assign rd_en    = r_rd_en;
    assign rd_addr  = r_rd_addr;
    assign rd_bank  = r_bank;
    assign rd_valid = r_vld_p[RD_LAT-1];
    assign rd_last  = r_last_p[RD_LAT-1];
    assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_pp_ram_rd_ctrl.sv
// Bench for pp_ram_rd_ctrl: default 2-bank instance with a scoreboard, plus a 4-bank RD_LAT=3 instance.
module tb_pp_ram_rd_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Default-parameter instance
    logic       rst, rd_ready;
    logic [1:0] wr_full, rd_done;
    logic       rd_en, rd_valid, rd_last, busy;
    logic [6:0] rd_addr;
    logic [0:0] rd_bank;

    pp_ram_rd_ctrl dut_a (
        .clk(clk), .rst(rst), .wr_full(wr_full), .rd_done(rd_done), .rd_ready(rd_ready),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_bank(rd_bank), .rd_valid(rd_valid),
        .rd_last(rd_last), .busy(busy)
    );

    // 4 banks, stride 16, depth 10, latency 3, hold 4
    logic       rst_b, rd_ready_b;
    logic [3:0] wr_full_b, rd_done_b;
    logic       rd_en_b, rd_valid_b, rd_last_b, busy_b;
    logic [5:0] rd_addr_b;
    logic [1:0] rd_bank_b;

    pp_ram_rd_ctrl #(
        .NUM_BANKS(4), .BANK_DEPTH(10), .BANK_STRIDE(16), .ADDR_W(6), .RD_LAT(3), .HOLD_CYCLES(4)
    ) dut_b (
        .clk(clk), .rst(rst_b), .wr_full(wr_full_b), .rd_done(rd_done_b), .rd_ready(rd_ready_b),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_bank(rd_bank_b), .rd_valid(rd_valid_b),
        .rd_last(rd_last_b), .busy(busy_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected read stream: each served bank contributes base..base+37 in order.
    int   exp_addr_q[$];
    int   exp_bank_q[$];
    int   en_cnt, vld_cnt, last_cnt, last_addr, prev_addr;
    logic prev_en, prev_last;

    task automatic push_bank(input int b);
        for (int i = 0; i < 38; i++) begin
            exp_addr_q.push_back(b * 64 + i);
            exp_bank_q.push_back(b);
        end
    endtask

    task automatic clr_cnt();
        en_cnt = 0; vld_cnt = 0; last_cnt = 0; last_addr = -1;
    endtask

    always @(posedge clk) begin
        #1;
        if (rst) begin
            prev_en   = 1'b0;
            prev_last = 1'b0;
        end else begin
            chk("a_valid", int'(rd_valid), int'(prev_en));
            chk("a_last", int'(rd_last), int'(prev_last));
            if (rd_valid) vld_cnt++;
            if (rd_last) begin
                last_cnt++;
                last_addr = prev_addr;
            end
            if (rd_en) begin
                en_cnt++;
                if (exp_addr_q.size() == 0) chk("a_unexpected_rd_en", 1, 0);
                else begin
                    chk("a_addr", int'(rd_addr), exp_addr_q.pop_front());
                    chk("a_bank", int'(rd_bank), exp_bank_q.pop_front());
                end
            end
            prev_en   = rd_en;
            prev_last = rd_en && ((int'(rd_addr) % 64) == 37);
            prev_addr = int'(rd_addr);
        end
    end

    task automatic chk_zero_a(input string tag);
        chk({tag, "_rd_done"}, int'(rd_done), 0);
        chk({tag, "_rd_en"}, int'(rd_en), 0);
        chk({tag, "_rd_addr"}, int'(rd_addr), 0);
        chk({tag, "_rd_bank"}, int'(rd_bank), 0);
        chk({tag, "_rd_valid"}, int'(rd_valid), 0);
        chk({tag, "_rd_last"}, int'(rd_last), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    task automatic wait_done(input string tag, input int exp_mask, input int hold);
        int  n;
        bit  seen;
        seen = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (rd_done != 2'b00) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            chk({tag, "_done_timeout"}, 0, 1);
            return;
        end
        chk({tag, "_done_mask"}, int'(rd_done), exp_mask);
        n = 0;
        while (rd_done != 2'b00 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_done_len"}, n, hold);
        chk({tag, "_busy_after"}, int'(busy), 0);
    endtask

    logic [3:0] pat = 4'b1001;
    int         tog_k;
    bit         t4_stop;
    logic       en_h [0:299];
    int first_en, last_en, last_cyc, done_cyc, done_len, done_mask, en_n, vld_n, next_addr;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; wr_full = 2'b00; rd_ready = 1'b1;
        rst_b = 1'b1; wr_full_b = 4'b0000; rd_ready_b = 1'b1;
        clr_cnt();
        repeat (3) @(negedge clk);
        chk_zero_a("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", int'(busy), 0);

        // Single bank 0, continuous ready
        clr_cnt(); push_bank(0); wr_full = 2'b01;
        wait_done("t1", 1, 20);
        chk("t1_en_count", en_cnt, 38);
        chk("t1_vld_count", vld_cnt, 38);
        chk("t1_last_count", last_cnt, 1);
        chk("t1_last_addr", last_addr, 37);
        chk("t1_queue_left", exp_addr_q.size(), 0);
        wr_full = 2'b00; repeat (2) @(negedge clk);

        // Bank 1, then no re-read while wr_full stays high
        clr_cnt(); push_bank(1); wr_full = 2'b10;
        wait_done("t2", 2, 20);
        chk("t2_en_count", en_cnt, 38);
        chk("t2_last_addr", last_addr, 101);
        clr_cnt();
        repeat (60) @(negedge clk);
        chk("t2_no_reread_en", en_cnt, 0);
        chk("t2_no_reread_busy", int'(busy), 0);
        wr_full = 2'b00; repeat (2) @(negedge clk);
        push_bank(1); wr_full = 2'b10;
        wait_done("t2b", 2, 20);
        chk("t2b_en_count", en_cnt, 38);
        wr_full = 2'b00; repeat (2) @(negedge clk);

        // Both banks full from reset: order 0, 1, 0
        rst = 1'b1; repeat (2) @(negedge clk); rst = 1'b0;
        clr_cnt(); push_bank(0); push_bank(1); push_bank(0);
        wr_full = 2'b11;
        wait_done("t3a", 1, 20);
        wr_full = 2'b10; repeat (2) @(negedge clk); wr_full = 2'b11;
        wait_done("t3b", 2, 20);
        wait_done("t3c", 1, 20);
        chk("t3_en_count", en_cnt, 114);
        chk("t3_queue_left", exp_addr_q.size(), 0);
        wr_full = 2'b00; repeat (2) @(negedge clk);

        // Backpressure pattern 1,0,0,1 on bank 0
        clr_cnt(); push_bank(0); wr_full = 2'b01;
        t4_stop = 1'b0; tog_k = 0;
        fork
            begin
                wait_done("t4", 1, 20);
                t4_stop = 1'b1;
            end
            begin
                while (!t4_stop && tog_k < 2000) begin
                    @(negedge clk);
                    rd_ready = pat[tog_k % 4];
                    tog_k++;
                end
            end
        join
        rd_ready = 1'b1;
        chk("t4_en_count", en_cnt, 38);
        chk("t4_vld_count", vld_cnt, 38);
        chk("t4_queue_left", exp_addr_q.size(), 0);
        wr_full = 2'b00; repeat (2) @(negedge clk);

        // Reset in the middle of bank 0
        clr_cnt(); push_bank(0); wr_full = 2'b01;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (en_cnt >= 20) break;
        end
        chk("t5_reached_word20", int'(en_cnt >= 20), 1);
        rst = 1'b1;
        exp_addr_q.delete(); exp_bank_q.delete();
        @(negedge clk);
        chk_zero_a("t5_abort");
        rst = 1'b0;
        clr_cnt(); push_bank(0);
        wait_done("t5", 1, 20);
        chk("t5_en_count", en_cnt, 38);
        chk("t5_last_addr", last_addr, 37);
        wr_full = 2'b00; repeat (2) @(negedge clk);

        // 4-bank instance, bank 2, latency 3
        rst_b = 1'b0;
        @(negedge clk);
        wr_full_b = 4'b0100;
        first_en = -1; last_en = -1; last_cyc = -1; done_cyc = -1; done_len = 0;
        done_mask = 0; en_n = 0; vld_n = 0; next_addr = 32;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk);
            #1;
            en_h[c] = rd_en_b;
            if (rd_en_b) begin
                if (first_en < 0) first_en = c;
                last_en = c;
                en_n++;
                chk("b_addr", int'(rd_addr_b), next_addr);
                chk("b_bank", int'(rd_bank_b), 2);
                next_addr++;
            end
            if (c >= 3) chk("b_valid_lag", int'(rd_valid_b), int'(en_h[c-3]));
            if (rd_valid_b) vld_n++;
            if (rd_last_b) last_cyc = c;
            if (rd_done_b != 4'b0000) begin
                if (done_cyc < 0) begin
                    done_cyc  = c;
                    done_mask = int'(rd_done_b);
                end
                done_len++;
            end else if (done_cyc >= 0) begin
                break;
            end
        end
        chk("b_en_count", en_n, 10);
        chk("b_vld_count", vld_n, 10);
        chk("b_end_addr", next_addr, 42);
        chk("b_last_lag", last_cyc - last_en, 3);
        chk("b_drain_len", done_cyc - last_en, 3);
        chk("b_done_mask", done_mask, 4);
        chk("b_done_len", done_len, 4);
        chk("b_busy_after", int'(busy_b), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
